// File: rtl/dff_chain_strobed_pkg.sv
// Shared lab package: chain mode encoding plus a small width helper.
package dff_chain_strobed_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_chain_strobed_strobe_gen.sv
// Free-running clock-enable prescaler: one-cycle strobe every DIV clocks.
module strobe_gen
  import dff_chain_strobed_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic strobe
);

  localparam int unsigned   CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With DIV=1 the counter sits at 0 == LAST, so strobe is held high.
  assign strobe = (cnt_q == LAST);

endmodule

// File: rtl/dff_chain_strobed.sv
// WIDTH x DEPTH register chain (hold/shift/rotate/fill) advanced on prescaler strobes.
// Define DFF_CHAIN_STROBED_SYNC_EN to pass d through a two-flop synchroniser.
module dff_chain_strobed
  import dff_chain_strobed_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV   = 50_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  output logic                         strobe,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH*DEPTH-1:0]       stages,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  mode_t            mode_w;
  logic             upd;
  logic [WIDTH-1:0] d_eff;
  logic [WIDTH-1:0] stage_w [DEPTH];

  assign mode_w = mode_t'(mode);

  strobe_gen #(
    .DIV (DIV)
  ) u_strobe_gen (
    .clock  (clock),
    .reset  (reset),
    .strobe (strobe)
  );

  assign upd = strobe & enable;

`ifdef DFF_CHAIN_STROBED_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign d_eff = sync2_q;
`else
  assign d_eff = d;
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] shift_src;
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;

    // Stage 0 takes fresh data when shifting and the tail word when rotating.
    if (gi == 0) begin : g_head
      assign shift_src = (mode_w == MODE_ROTATE) ? stage_w[DEPTH-1] : d_eff;
    end else begin : g_tail
      assign shift_src = stage_w[gi-1];
    end

    always_comb begin
      stage_d = stage_q;
      if (upd) begin
        case (mode_w)
          MODE_SHIFT, MODE_ROTATE: stage_d = shift_src;
          MODE_FILL:               stage_d = d_eff;
          default:                 stage_d = stage_q;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign stage_w[gi]                = stage_q;
    assign stages[gi*WIDTH +: WIDTH]  = stage_q;
  end

  assign q = stage_w[DEPTH-1];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;

  always_comb begin
    count_d = count_q;
    if (upd) begin
      case (mode_w)
        MODE_SHIFT: if (count_q != DEPTH_C) count_d = count_q + CNT_W'(1);
        MODE_FILL:  count_d = DEPTH_C;
        default:    count_d = count_q;
      endcase
    end
  end

  // full is registered from count_d so it changes in the same cycle as count.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
    end
  end

  assign count = count_q;
  assign full  = full_q;

endmodule

// File: tb/tb_dff_chain_strobed.sv
// Directed bench for dff_chain_strobed with WIDTH=4, DEPTH=4, DIV=4.
module tb_dff_chain_strobed;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [3:0]  d;
  logic        strobe;
  logic [3:0]  q;
  logic [15:0] stages;
  logic [2:0]  count;
  logic        full;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] HOLD = 2'd0, SHIFT = 2'd1, ROTATE = 2'd2, FILL = 2'd3;

  dff_chain_strobed #(
    .WIDTH (4),
    .DEPTH (4),
    .DIV   (4)
  ) dut (
    .clock  (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .d      (d),
    .strobe (strobe),
    .q      (q),
    .stages (stages),
    .count  (count),
    .full   (full)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [15:0] st, input logic [2:0] cnt,
                           input logic fl);
    chk({tag, "_stages"}, stages, st);
    chk({tag, "_q"}, {12'h0, q}, {12'h0, st[15:12]});
    chk({tag, "_count"}, {13'h0, count}, {13'h0, cnt});
    chk({tag, "_full"}, {15'h0, full}, {15'h0, fl});
  endtask

  // Advance until the strobe cycle; the number of cycles taken is checked.
  task automatic wait_strobe(input string tag, input int exp_n);
    int n = 0;
    while (strobe !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 16'(n), 16'(exp_n));
  endtask

  task automatic step(input string tag);
    wait_strobe(tag, 3);
    tick();
  endtask

  logic [15:0] shift_exp [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};
  logic [15:0] rot_exp   [4] = '{16'h2341, 16'h3412, 16'h4123, 16'h1234};

  initial begin
    reset = 1'b1; enable = 1'b0; mode = HOLD; d = 4'h0;
    tick();
    tick();
    chk_state("reset", 16'h0000, 3'd0, 1'b0);
    chk("reset_strobe", {15'h0, strobe}, 16'h0);
    reset = 1'b0;

    wait_strobe("first", 3);
    tick();
    chk_state("no_enable", 16'h0000, 3'd0, 1'b0);

    mode = SHIFT; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 4'(k + 1);
      wait_strobe("shift", 3);
      if (k == 0) chk("latency_stages", stages, 16'h0000);
      tick();
      chk_state("shift", shift_exp[k], 3'(k + 1), (k == 3));
    end

    mode = ROTATE;
    for (int k = 0; k < 4; k++) begin
      step("rotate");
      chk_state("rotate", rot_exp[k], 3'd4, 1'b1);
    end

    mode = SHIFT; d = 4'h5;
    step("shift_full");
    chk_state("shift_full", 16'h2345, 3'd4, 1'b1);

    mode = FILL; d = 4'hA;
    wait_strobe("fill", 3);
    chk("fill_pre", stages, 16'h2345);
    tick();
    chk_state("fill", 16'hAAAA, 3'd4, 1'b1);

    enable = 1'b0; mode = SHIFT; d = 4'h3;
    for (int k = 0; k < 3; k++) begin
      step("disabled");
      chk_state("disabled", 16'hAAAA, 3'd4, 1'b1);
    end

    // Mode flips between strobes must be ignored; HOLD at the strobe wins.
    enable = 1'b1; mode = SHIFT; d = 4'h5;
    tick();
    mode = HOLD;
    tick();
    mode = SHIFT;
    tick();
    chk("toggle_strobe", {15'h0, strobe}, 16'h1);
    mode = HOLD;
    tick();
    chk_state("toggle", 16'hAAAA, 3'd4, 1'b1);

    mode = SHIFT; d = 4'h7;
    wait_strobe("rst_strobe", 3);
    reset = 1'b1;
    tick();
    chk_state("rst_mid", 16'h0000, 3'd0, 1'b0);
    chk("rst_mid_strobe", {15'h0, strobe}, 16'h0);
    reset = 1'b0;
    wait_strobe("restart", 3);
    tick();
    chk_state("post_rst", 16'h0007, 3'd1, 1'b0);

    d = 4'h6;
    step("shift6");
    chk_state("shift6", 16'h0076, 3'd2, 1'b0);

    // d changed one cycle before the strobe.
    tick();
    tick();
    d = 4'h9;
    tick();
    chk("late_strobe", {15'h0, strobe}, 16'h1);
    tick();
`ifdef DFF_CHAIN_STROBED_SYNC_EN
    chk_state("late_d", 16'h0766, 3'd3, 1'b0);
`else
    chk_state("late_d", 16'h0769, 3'd3, 1'b0);
`endif

    // d changed two cycles before the strobe.
    tick();
    d = 4'h8;
    tick();
    tick();
    chk("early_strobe", {15'h0, strobe}, 16'h1);
    tick();
`ifdef DFF_CHAIN_STROBED_SYNC_EN
    chk_state("early_d", 16'h7668, 3'd4, 1'b1);
`else
    chk_state("early_d", 16'h7698, 3'd4, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
